// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter: default parameter values
// and the arbiter FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  // Default sizing used by the arbiter and its picker
  localparam int DEFAULT_NUM_REQ          = 4;
  localparam int DEFAULT_DATA_WIDTH       = 8;
  localparam int DEFAULT_BUSY_TIMEOUT     = 64;

  // Arbiter FSM states; IDLE is encoded as zero so reset lands there
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_rr_picker.sv
// -----------------------------------------------------------------------------
// uart_rr_picker
// Combinational round-robin selector. Starting at index ptr_i and wrapping
// modulo NUM_REQ, returns the first asserted request.
// Ports:
//   req_i    [NUM_REQ-1:0]  request vector
//   ptr_i    [IDX_W-1:0]    highest-priority index for this round
//   valid_o                 at least one request asserted
//   winner_o [IDX_W-1:0]    index of the selected request (0 when !valid_o)
// -----------------------------------------------------------------------------
module uart_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   winner_o
);

  // Scan offsets from the farthest to the nearest so the nearest asserted
  // request (lowest offset from ptr) is the last one written and wins,
  // which avoids needing an early exit from the loop.
  always_comb begin
    int idx;
    valid_o  = 1'b0;
    winner_o = '0;
    idx      = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr_i) + i) % NUM_REQ;
      if (req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter that lets NUM_REQ requesters share one UART transmitter.
// A winner's byte is latched, presented on i_data and launched with a
// one-cycle enable; the arbiter then waits for the UART to go busy and idle
// again before serving the next request. If busy never rises within
// BUSY_TIMEOUT cycles of the enable, timeout_err pulses and the arbiter
// returns to IDLE.
// Ports:
//   clk, reset         sole clock; synchronous active-high reset
//   req      [N]       per-requester level request
//   req_data [N*W]     packed bytes, requester k at [k*W +: W]
//   grant    [N]       one-hot acceptance pulse (ISSUE cycle only)
//   enable             UART enable pulse (ISSUE cycle only)
//   i_data   [W]       byte to the UART, held between transfers
//   o_busy             UART busy indication
//   owner    [log2 N]  index of the requester being served
//   active             high whenever the FSM is not in IDLE
//   timeout_err        one-cycle pulse when busy fails to rise in time
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ          = DEFAULT_NUM_REQ,
  parameter int INPUT_DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BUSY_TIMEOUT     = DEFAULT_BUSY_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*INPUT_DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          enable,
  output logic [INPUT_DATA_WIDTH-1:0]   i_data,
  input  logic                          o_busy,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          active,
  output logic                          timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  // WAIT_BUSY is entered one cycle after enable, so the counter fires on
  // value BUSY_TIMEOUT-2 to make the registered pulse land exactly
  // BUSY_TIMEOUT cycles after the enable cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 2);

  arb_state_e                  state_q;
  logic [IDX_W-1:0]            ptr_q;
  logic [IDX_W-1:0]            ptr_d;
  logic [IDX_W-1:0]            owner_q;
  logic [INPUT_DATA_WIDTH-1:0] data_q;
  logic [INPUT_DATA_WIDTH-1:0] data_d;
  logic [CNT_W-1:0]            cnt_q;
  logic [NUM_REQ-1:0]          grant_q;
  logic                        enable_q;
  logic                        timeout_q;

  logic                        pickValid;
  logic [IDX_W-1:0]            pickWinner;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .valid_o  (pickValid),
    .winner_o (pickWinner)
  );

  // Candidate values taken on a grant: the winner's byte and the pointer
  // position just past the winner, wrapping at NUM_REQ.
  always_comb begin
    data_d = req_data[pickWinner*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
    if (int'(pickWinner) == NUM_REQ - 1) begin
      ptr_d = '0;
    end else begin
      ptr_d = pickWinner + IDX_W'(1);
    end
  end

  // Arbiter FSM with registered outputs. grant, enable and timeout_err are
  // pulses, so they default low every cycle and are only raised on the
  // transition that should make them visible. The data register is loaded
  // only from IDLE with o_busy low, so i_data can never move while the UART
  // is busy. The pointer moves only on a grant; a timeout leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      enable_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      grant_q   <= '0;
      enable_q  <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pickValid && !o_busy) begin
            data_q   <= data_d;
            owner_q  <= pickWinner;
            ptr_q    <= ptr_d;
            grant_q  <= NUM_REQ'(1) << pickWinner;
            enable_q <= 1'b1;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (o_busy) begin
            state_q <= ST_WAIT_DONE;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!o_busy) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // active is the only output decoded directly from state
  assign active      = (state_q != ST_IDLE);
  assign grant       = grant_q;
  assign enable      = enable_q;
  assign i_data      = data_q;
  assign owner       = owner_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter. The bench plays the UART by
// driving o_busy directly and predicts each grant from the round-robin rule
// applied to the request mask and a remembered pointer.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 64;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         req;
  logic [N*W-1:0]       reqData;
  logic [N-1:0]         grant;
  logic                 enable;
  logic [W-1:0]         iData;
  logic                 oBusy;
  logic [$clog2(N)-1:0] owner;
  logic                 active;
  logic                 timeoutErr;

  int checks   = 0;
  int failures = 0;

  // Reference state: next round-robin start and the byte the UART should see
  int         modelPtr  = 0;
  logic [W-1:0] modelData = '0;
  logic [W-1:0] bytes [N];

  uart_tx_arbiter #(
    .NUM_REQ          (N),
    .INPUT_DATA_WIDTH (W),
    .BUSY_TIMEOUT     (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (reqData),
    .grant       (grant),
    .enable      (enable),
    .i_data      (iData),
    .o_busy      (oBusy),
    .owner       (owner),
    .active      (active),
    .timeout_err (timeoutErr)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // One comparison: counts it, asserts equality, reports on failure
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first asserted request at ptr, ptr+1, ... mod N
  function automatic int rrPick(input logic [N-1:0] mask, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (mask[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  // Advance one clock, sample 1 time unit after the edge and check the
  // always-true properties: one-hot grant, enable tied to grant, and i_data
  // equal to the last accepted byte.
  task automatic tick();
    @(posedge clk);
    #1;
    checkOutput("grantOnehot0", 32'($onehot0(grant)), 32'd1);
    checkOutput("enableEqOrGrant", 32'(enable), 32'(|grant));
    checkOutput("iDataHeld", 32'(iData), 32'(modelData));
  endtask

  // Drive a request mask, optionally with fresh random bytes per requester
  task automatic applyStimulus(input logic [N-1:0] mask, input bit newData);
    if (newData) begin
      for (int k = 0; k < N; k++) bytes[k] = W'($urandom);
    end
    for (int k = 0; k < N; k++) reqData[k*W +: W] = bytes[k];
    req = mask;
  endtask

  // From IDLE with o_busy low: present the mask, step one edge and expect
  // the predicted winner to be granted together with enable.
  task automatic startTransfer(input logic [N-1:0] mask, input bit newData, input int forceByte);
    int w;
    if (newData) begin
      for (int k = 0; k < N; k++) bytes[k] = W'($urandom);
    end
    w = rrPick(mask, modelPtr);
    if (forceByte >= 0) bytes[w] = W'(forceByte);
    applyStimulus(mask, 1'b0);
    modelData = bytes[w];
    tick();
    checkOutput("grant", 32'(grant), 32'(1) << w);
    checkOutput("enable", 32'(enable), 32'd1);
    checkOutput("owner", 32'(owner), 32'(w));
    checkOutput("activeIssue", 32'(active), 32'd1);
    checkOutput("iDataIssue", 32'(iData), 32'(bytes[w]));
    modelPtr = (w + 1) % N;
  endtask

  // After a grant: wait `delay` extra cycles, raise busy for `len` cycles,
  // drop it, and expect the arbiter back in IDLE on the following edge.
  task automatic finishTransfer(input int delay, input int len);
    tick();
    checkOutput("enableAfterIssue", 32'(enable), 32'd0);
    checkOutput("activeWaitBusy", 32'(active), 32'd1);
    for (int i = 0; i < delay; i++) begin
      tick();
      checkOutput("activeWaitBusyLoop", 32'(active), 32'd1);
    end
    oBusy = 1'b1;
    for (int i = 0; i < len; i++) begin
      tick();
      checkOutput("grantWhileBusy", 32'(grant), 32'd0);
      checkOutput("activeWaitDone", 32'(active), 32'd1);
    end
    oBusy = 1'b0;
    tick();
    checkOutput("activeBackIdle", 32'(active), 32'd0);
    checkOutput("noTimeout", 32'(timeoutErr), 32'd0);
  endtask

  // Directed sequence followed by randomized transfers
  initial begin
    reset   = 1'b1;
    oBusy   = 1'b0;
    req     = '0;
    reqData = '0;
    for (int k = 0; k < N; k++) bytes[k] = '0;

    // Reset state
    tick();
    tick();
    checkOutput("rstGrant", 32'(grant), 32'd0);
    checkOutput("rstEnable", 32'(enable), 32'd0);
    checkOutput("rstActive", 32'(active), 32'd0);
    checkOutput("rstOwner", 32'(owner), 32'd0);
    checkOutput("rstTimeout", 32'(timeoutErr), 32'd0);
    checkOutput("rstIData", 32'(iData), 32'd0);
    reset = 1'b0;
    tick();

    // Single requester, known byte
    startTransfer(4'b0010, 1'b1, 8'hA5);
    req = '0;
    finishTransfer(2, 5);
    checkOutput("singleIData", 32'(iData), 32'hA5);

    // All requesters held continuously, starting from a fresh pointer
    reset = 1'b1;
    modelPtr  = 0;
    modelData = '0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < N; k++) bytes[k] = W'($urandom);
    for (int t = 0; t < 5; t++) begin
      startTransfer(4'b1111, 1'b0, -1);
      checkOutput("rrOrder", 32'(owner), 32'(t % N));
      finishTransfer(1, 3);
    end
    req = '0;

    // Busy while idle: nothing may be issued
    oBusy = 1'b1;
    applyStimulus(4'b0100, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("busyIdleGrant", 32'(grant), 32'd0);
      checkOutput("busyIdleActive", 32'(active), 32'd0);
    end
    oBusy = 1'b0;
    startTransfer(4'b0100, 1'b0, -1);
    req = '0;
    finishTransfer(0, 2);

    // Withdrawal: req[2] appears and vanishes during another transfer
    startTransfer(4'b0001, 1'b1, -1);
    req = '0;
    tick();
    oBusy = 1'b1;
    tick();
    applyStimulus(4'b0100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("withdrawGrant", 32'(grant), 32'd0);
    end
    req = '0;
    tick();
    oBusy = 1'b0;
    tick();
    checkOutput("withdrawIdle", 32'(active), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("withdrawNoGrant", 32'(grant), 32'd0);
      checkOutput("withdrawActive", 32'(active), 32'd0);
    end

    // Timeout: busy never rises; pulse exactly TO cycles after enable
    startTransfer(4'b0001, 1'b1, -1);
    req = '0;
    for (int k = 1; k <= TO + 1; k++) begin
      tick();
      checkOutput($sformatf("timeoutPulse@%0d", k), 32'(timeoutErr), 32'(k == TO));
      checkOutput($sformatf("timeoutActive@%0d", k), 32'(active), 32'(k < TO));
    end
    // Pointer must not have moved on the timeout
    startTransfer(4'b1111, 1'b1, -1);
    req = '0;
    finishTransfer(3, 4);

    // Reset while in WAIT_DONE
    startTransfer(4'b1010, 1'b1, -1);
    req = '0;
    tick();
    oBusy = 1'b1;
    tick();
    reset     = 1'b1;
    modelData = '0;
    tick();
    checkOutput("midRstEnable", 32'(enable), 32'd0);
    checkOutput("midRstGrant", 32'(grant), 32'd0);
    checkOutput("midRstActive", 32'(active), 32'd0);
    checkOutput("midRstOwner", 32'(owner), 32'd0);
    checkOutput("midRstTimeout", 32'(timeoutErr), 32'd0);
    reset    = 1'b0;
    oBusy    = 1'b0;
    modelPtr = 0;
    startTransfer(4'b1111, 1'b1, -1);
    req = '0;
    finishTransfer(1, 2);

    // Randomized transfers against the round-robin model
    for (int t = 0; t < 30; t++) begin
      startTransfer(N'($urandom_range(1, (1 << N) - 1)), 1'b1, -1);
      if ($urandom_range(0, 1) == 0) req = '0;
      finishTransfer(int'($urandom_range(0, 10)), int'($urandom_range(1, 12)));
      req = '0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter INPUT_DATA_WIDTH, default 8: byte width, equal to the UART's i_data width.
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 64: max cycles from enable pulse to o_busy rising.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  input  1  sole clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-requester transmit request, level.
REQ-007 req_data  input  NUM_REQ*INPUT_DATA_WIDTH  packed bytes, requester k at bits [k*W +: W].
REQ-008 grant  output  NUM_REQ  one-hot, one-cycle acceptance pulse.
REQ-009 enable  output  1  to UART enable.
REQ-010 i_data  output  INPUT_DATA_WIDTH  to UART i_data.
REQ-011 o_busy  input  1  from UART o_busy.
REQ-012 owner  output  clog2(NUM_REQ)  index of the requester currently being served.
REQ-013 active  output  1  high whenever state != IDLE.
REQ-014 timeout_err  output  1  one-cycle pulse on busy timeout.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-016 IDLE: if |req && !o_busy, select winner k round-robin from pointer ptr, latch req_data[k] into the data register and owner<=k, and go to ISSUE; otherwise stay.
REQ-017 Round-robin: winner = first asserted req at index ptr, ptr+1, ... mod NUM_REQ; after a grant, ptr <= (k+1) mod NUM_REQ.
REQ-018 ISSUE (exactly 1 cycle): enable=1, grant[k]=1, then go to WAIT_BUSY; enable and grant SHALL be 0 in every other state.
REQ-019 Latency: req sampled in IDLE at cycle T -> enable/grant high at T+1.
REQ-020 i_data SHALL equal the latched byte from ISSUE through WAIT_DONE and hold its value in IDLE; it SHALL never change while o_busy=1.
REQ-021 WAIT_BUSY: o_busy=1 -> WAIT_DONE; a cycle counter counts cycles in WAIT_BUSY; on reaching BUSY_TIMEOUT without o_busy, pulse timeout_err for 1 cycle and go to IDLE.
REQ-022 WAIT_DONE: o_busy=0 -> IDLE; no timeout in this state.
REQ-023 A requester SHALL hold req and its data stable until grant; dropping req before grant is legal and yields no grant.
REQ-024 The requester may re-assert req in the cycle after grant; it is then arbitrated normally in the next IDLE.
REQ-025 Only one new request is considered per IDLE visit; back-to-back transfers therefore have a minimum one-cycle IDLE gap.
REQ-026 If o_busy=1 while in IDLE (foreign or residual), SHALL not issue and SHALL stay in IDLE.
REQ-027 ptr SHALL not advance on timeout, so the timed-out requester is not retried ahead of others.

Reset
REQ-028 On reset: state=IDLE, ptr=0, owner=0, data register=0, counter=0, enable=0, grant=0, timeout_err=0, active=0, effective at the next clock edge.
REQ-029 Reset mid-transfer SHALL abort to IDLE with no grant or timeout pulse; the UART is reset by the same signal.

Structure
REQ-030 FSM state encoding and default widths SHALL live in shared package uart_pkg.
REQ-031 Combinational round-robin selection SHALL be sub-module uart_rr_picker (inputs req, ptr; outputs valid, winner index).
REQ-032 All outputs SHALL be registered except active, which is decoded from state.

Verification
REQ-033 Single requester: req=4'b0010, data1=8'hA5 -> grant=4'b0010 and enable=1 one cycle later, i_data=8'hA5; a UART loopback receives 8'hA5 with no rx_error.
REQ-034 All requesters: req=4'b1111 held continuously -> grant order 0,1,2,3,0; each grant only after o_busy falls.
REQ-035 Timeout: o_busy tied 0, req=4'b0001 -> timeout_err pulses exactly 64 cycles after enable, then returns to IDLE, ptr unchanged.
REQ-036 Withdrawal: req[2] raised then dropped before grant while another transfer is in progress -> grant[2] never asserts.
REQ-037 Reset mid-transfer in WAIT_DONE -> next cycle enable=0, grant=0, active=0, owner=0; next request is granted from ptr=0.
REQ-038 Formal properties: grant is onehot0; enable==|grant; i_data is stable while o_busy=1.
